// File: rtl/disp_write_sched_pkg.sv
// Shared display-side definitions: digit geometry and the write-scheduler FSM states.
package disp_write_sched_pkg;

  localparam int unsigned NumDigits = 6;
  localparam int unsigned DigitW    = 4;
  localparam int unsigned FrameW    = NumDigits * DigitW;
  localparam int unsigned IdxW      = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StHold
  } disp_state_e;

  // Digit idx of a packed frame; digit k occupies bits [4k+3:4k].
  function automatic logic [DigitW-1:0] frame_digit(input logic [FrameW-1:0] frame,
                                                    input logic [IdxW-1:0]   idx);
    return frame[{idx, 2'b00} +: DigitW];
  endfunction

endpackage

// File: rtl/disp_write_sched_if.sv
// Requester handshakes plus the digit-register write port driven by the scheduler.
interface disp_write_sched_if;
  import disp_write_sched_pkg::*;

  logic              a_valid;
  logic [FrameW-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [FrameW-1:0] b_data;
  logic              b_ready;
  logic              en;
  logic [IdxW-1:0]   bit_sel;
  logic [DigitW-1:0] data_in;
  logic              busy;
  logic              frame_done;
  logic              last_grant;

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, en, bit_sel, data_in, busy, frame_done, last_grant
  );

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, en, bit_sel, data_in, busy, frame_done, last_grant
  );

endinterface

// File: rtl/disp_write_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the side that wins a tie (0 = A, 1 = B).
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    // After any grant the pointer favours the side that lost.
    ptr_d = ptr_q;
    if (gnt_o != 2'b00) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/disp_write_sched.sv
// Arbitrates two frame requesters and writes the granted frame into the six digit registers.
module disp_write_sched
  import disp_write_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 0
) (
  input logic              clk_50M,
  input logic              rst,
  disp_write_sched_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumDigits - 1);

  disp_state_e       state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [FrameW-1:0] shadow_q, shadow_d;
  logic              last_grant_q, last_grant_d;
  logic              en_q, en_d;
  logic [IdxW-1:0]   bit_sel_q, bit_sel_d;
  logic [DigitW-1:0] data_in_q, data_in_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .clk_i (clk_50M),
    .rst_i (rst),
    .req_i ({bus.b_valid, bus.a_valid}),
    .en_i  ((state_q == StIdle) && !rst),
    .gnt_o (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    shadow_d     = shadow_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          shadow_d     = gnt[1] ? bus.b_data : bus.a_data;
          last_grant_d = gnt[1];
          idx_d        = '0;
          state_d      = StWrite;
        end
      end
      StWrite: begin
        if (idx_q == LastIdx) begin
          idx_d = '0;
          if (HOLD_CYCLES > 0) begin
            state_d = StHold;
            hold_d  = HoldLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_q <= HoldW'(1)) state_d = StIdle;
        else                     hold_d  = hold_q - HoldW'(1);
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so derive them from the upcoming state.
    en_d         = (state_d == StWrite);
    bit_sel_d    = en_d ? idx_d : '0;
    data_in_d    = en_d ? frame_digit(shadow_d, idx_d) : '0;
    frame_done_d = en_d && (idx_d == LastIdx);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      hold_q       <= '0;
      shadow_q     <= '0;
      last_grant_q <= 1'b0;
      en_q         <= 1'b0;
      bit_sel_q    <= '0;
      data_in_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      shadow_q     <= shadow_d;
      last_grant_q <= last_grant_d;
      en_q         <= en_d;
      bit_sel_q    <= bit_sel_d;
      data_in_q    <= data_in_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.en         = en_q;
  assign bus.bit_sel    = bit_sel_q;
  assign bus.data_in    = data_in_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.last_grant = last_grant_q;

endmodule

// File: tb/tb_disp_write_sched.sv
// Bench for disp_write_sched: one instance with no hold gap and one with HOLD_CYCLES=3.
module tb_disp_write_sched;
  import disp_write_sched_pkg::*;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [23:0] a_data, b_data;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [3:0]  bank [6];

  disp_write_sched_if if0 ();
  disp_write_sched_if if3 ();

  assign if0.a_valid = a_valid;
  assign if0.a_data  = a_data;
  assign if0.b_valid = b_valid;
  assign if0.b_data  = b_data;
  assign if3.a_valid = a_valid;
  assign if3.a_data  = a_data;
  assign if3.b_valid = b_valid;
  assign if3.b_data  = b_data;

  disp_write_sched #(.HOLD_CYCLES(0)) dut0 (.clk_50M(clk_50M), .rst(rst), .bus(if0.slave));
  disp_write_sched #(.HOLD_CYCLES(3)) dut3 (.clk_50M(clk_50M), .rst(rst), .bus(if3.slave));

  always #10 clk_50M = ~clk_50M;

  // Digit-register bank fed by dut0, as the display datapath would be.
  always @(posedge clk_50M) begin
    if (if0.en === 1'b1 && if0.bit_sel < 3'd6) bank[if0.bit_sel] <= if0.data_in;
  end

  typedef struct {
    logic        a_v;
    logic [23:0] a_d;
    logic        b_v;
    logic [23:0] b_d;
    logic        a_rdy;
    logic        b_rdy;
    logic        en;
    logic [2:0]  sel;
    logic [3:0]  din;
    logic        done;
    logic        busy;
    logic        lg;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_50M);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk_50M);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Transaction-level reference: a frame accepted at cycle t writes digit d at t+1+d,
  // keeps busy through t+6+hold, and the next acceptance is possible from t+7+hold.
  task automatic run_random(input int n);
    int          m_acc [2];
    logic        m_act [2];
    logic [23:0] m_frame [2];
    logic        m_ptr [2];
    logic        m_lg [2];
    int          hold [2];
    hold[0] = 0;
    hold[1] = 3;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_acc[k] = 0; m_frame[k] = '0; m_ptr[k] = 1'b0; m_lg[k] = 1'b0;
    end
    for (int t = 0; t < n; t++) begin
      rst     = ($urandom_range(0, 199) == 0);
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_data  = 24'($urandom);
      b_data  = 24'($urandom);
      sample();
      for (int k = 0; k < 2; k++) begin
        int         d;
        logic       e_en, e_done, e_busy, free, ga, gb;
        logic [2:0] e_sel;
        logic [3:0] e_din;
        logic       x_ar, x_br, x_en, x_done, x_busy, x_lg;
        logic [2:0] x_sel;
        logic [3:0] x_din;
        d      = m_act[k] ? t - m_acc[k] : 1000;
        e_en   = (d >= 1) && (d <= 6);
        e_sel  = e_en ? 3'(d - 1) : 3'd0;
        e_din  = e_en ? 4'(m_frame[k] >> (4 * (d - 1))) : 4'd0;
        e_done = (d == 6);
        e_busy = (d >= 1) && (d <= 6 + hold[k]);
        free   = !m_act[k] || (d >= 7 + hold[k]);
        ga = 1'b0;
        gb = 1'b0;
        if (!rst && free) begin
          if (a_valid && (!b_valid || !m_ptr[k])) ga = 1'b1;
          else if (b_valid)                       gb = 1'b1;
        end
        if (k == 0) begin
          x_ar = if0.a_ready; x_br = if0.b_ready; x_en = if0.en; x_sel = if0.bit_sel;
          x_din = if0.data_in; x_done = if0.frame_done; x_busy = if0.busy; x_lg = if0.last_grant;
        end else begin
          x_ar = if3.a_ready; x_br = if3.b_ready; x_en = if3.en; x_sel = if3.bit_sel;
          x_din = if3.data_in; x_done = if3.frame_done; x_busy = if3.busy; x_lg = if3.last_grant;
        end
        chk($sformatf("rnd%0d.a_ready", k), 32'(x_ar), 32'(ga));
        chk($sformatf("rnd%0d.b_ready", k), 32'(x_br), 32'(gb));
        chk($sformatf("rnd%0d.en", k), 32'(x_en), 32'(e_en));
        chk($sformatf("rnd%0d.bit_sel", k), 32'(x_sel), 32'(e_sel));
        chk($sformatf("rnd%0d.data_in", k), 32'(x_din), 32'(e_din));
        chk($sformatf("rnd%0d.frame_done", k), 32'(x_done), 32'(e_done));
        chk($sformatf("rnd%0d.busy", k), 32'(x_busy), 32'(e_busy));
        chk($sformatf("rnd%0d.last_grant", k), 32'(x_lg), 32'(m_lg[k]));
        if (rst) begin
          m_act[k] = 1'b0; m_ptr[k] = 1'b0; m_lg[k] = 1'b0;
        end else if (ga || gb) begin
          m_act[k]   = 1'b1;
          m_acc[k]   = t;
          m_frame[k] = ga ? a_data : b_data;
          m_ptr[k]   = ga;
          m_lg[k]    = gb;
        end
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acc_c [$];
    logic       acc_s [$];
    int         both, en_cnt;
    logic       seen, lg_pend, lg_side;

    // Reset: readies held low even with both requesters valid.
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = '0; b_data = '0;
    sample();
    chk("rst.a_ready", 32'(if0.a_ready), 0);
    chk("rst.b_ready", 32'(if0.b_ready), 0);
    next_cycle();
    sample();
    chk("rst.en", 32'(if0.en), 0);
    chk("rst.bit_sel", 32'(if0.bit_sel), 0);
    chk("rst.data_in", 32'(if0.data_in), 0);
    chk("rst.busy", 32'(if0.busy), 0);
    chk("rst.frame_done", 32'(if0.frame_done), 0);
    chk("rst.last_grant", 32'(if0.last_grant), 0);
    chk("rst.a_ready2", 32'(if0.a_ready), 0);
    next_cycle();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    // Single A frame 0x543210, one row per cycle.
    for (int i = 0; i < 8; i++) begin
      tbl[i].a_v   = (i == 0);
      tbl[i].a_d   = 24'h543210;
      tbl[i].b_v   = 1'b0;
      tbl[i].b_d   = 24'h0;
      tbl[i].a_rdy = (i == 0);
      tbl[i].b_rdy = 1'b0;
      tbl[i].en    = (i >= 1) && (i <= 6);
      tbl[i].sel   = tbl[i].en ? 3'(i - 1) : 3'd0;
      tbl[i].din   = tbl[i].en ? 4'(i - 1) : 4'd0;
      tbl[i].done  = (i == 6);
      tbl[i].busy  = tbl[i].en;
      tbl[i].lg    = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      a_valid = tbl[i].a_v; a_data = tbl[i].a_d; b_valid = tbl[i].b_v; b_data = tbl[i].b_d;
      sample();
      chk($sformatf("tbl%0d.a_ready", i), 32'(if0.a_ready), 32'(tbl[i].a_rdy));
      chk($sformatf("tbl%0d.b_ready", i), 32'(if0.b_ready), 32'(tbl[i].b_rdy));
      chk($sformatf("tbl%0d.en", i), 32'(if0.en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d.bit_sel", i), 32'(if0.bit_sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d.data_in", i), 32'(if0.data_in), 32'(tbl[i].din));
      chk($sformatf("tbl%0d.frame_done", i), 32'(if0.frame_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d.busy", i), 32'(if0.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d.last_grant", i), 32'(if0.last_grant), 32'(tbl[i].lg));
      next_cycle();
    end
    for (int i = 0; i < 6; i++) chk($sformatf("single.digit%0d", i), 32'(bank[i]), 32'(i));

    // Contention: both valid continuously from reset.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 24'hAAAAAA; b_data = 24'hBBBBBB;
    both = 0; lg_pend = 1'b0; lg_side = 1'b0;
    for (int c = 0; c < 28; c++) begin
      sample();
      if (lg_pend) chk($sformatf("cont.last_grant@%0d", c), 32'(if0.last_grant), 32'(lg_side));
      lg_pend = 1'b0;
      if (if0.a_ready && if0.b_ready) both++;
      if (if0.a_ready) begin acc_c.push_back(c); acc_s.push_back(1'b0); lg_pend = 1'b1; lg_side = 1'b0; end
      if (if0.b_ready) begin acc_c.push_back(c); acc_s.push_back(1'b1); lg_pend = 1'b1; lg_side = 1'b1; end
      next_cycle();
    end
    chk("cont.accepts", 32'(acc_c.size()), 4);
    chk("cont.both_ready", 32'(both), 0);
    for (int k = 0; k < 4; k++) begin
      if (k < acc_c.size()) begin
        chk($sformatf("cont.cycle%0d", k), 32'(acc_c[k]), 32'(7 * k));
        chk($sformatf("cont.side%0d", k), 32'(acc_s[k]), 32'(k % 2));
      end
    end

    // Hold gap on the HOLD_CYCLES=3 instance.
    do_reset();
    a_valid = 1'b0; b_valid = 1'b1; b_data = 24'hFFFFFF;
    for (int c = 0; c < 31; c++) begin
      sample();
      chk($sformatf("hold.busy@%0d", c), 32'(if3.busy), 32'((c % 10) != 0));
      chk($sformatf("hold.b_ready@%0d", c), 32'(if3.b_ready), 32'((c % 10) == 0));
      next_cycle();
    end
    b_valid = 1'b0;

    // Valid withdrawn: A pulses during B's frame; pointer must stay at A.
    do_reset();
    b_valid = 1'b1; b_data = 24'h0F0F0F; a_data = 24'h777777;
    sample();
    chk("wd.b_ready0", 32'(if0.b_ready), 1);
    next_cycle();
    b_valid = 1'b0;
    seen = 1'b0; en_cnt = 0;
    for (int c = 1; c < 8; c++) begin
      a_valid = (c == 3);
      sample();
      if (if0.a_ready || if0.b_ready) seen = 1'b1;
      if (if0.en) en_cnt++;
      next_cycle();
    end
    chk("wd.no_accept", 32'(seen), 0);
    chk("wd.en_count", 32'(en_cnt), 6);
    a_valid = 1'b1; b_valid = 1'b1;
    sample();
    chk("wd.ptr_a_ready", 32'(if0.a_ready), 1);
    chk("wd.ptr_b_ready", 32'(if0.b_ready), 0);
    next_cycle();
    a_valid = 1'b0; b_valid = 1'b0;

    // Reset mid-frame: preload 9s, then abort a frame after digits 0-1 are written.
    do_reset();
    b_valid = 1'b1; b_data = 24'h999999;
    sample();
    chk("mid.pre_ready", 32'(if0.b_ready), 1);
    next_cycle();
    b_valid = 1'b0;
    repeat (6) next_cycle();
    b_valid = 1'b1; b_data = 24'h123456;
    sample();
    chk("mid.ready", 32'(if0.b_ready), 1);
    next_cycle();
    b_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    sample();
    chk("mid.sel_at_rst", 32'(if0.bit_sel), 1);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("mid.en", 32'(if0.en), 0);
    chk("mid.busy", 32'(if0.busy), 0);
    chk("mid.bit_sel", 32'(if0.bit_sel), 0);
    chk("mid.data_in", 32'(if0.data_in), 0);
    chk("mid.frame_done", 32'(if0.frame_done), 0);
    chk("mid.last_grant", 32'(if0.last_grant), 0);
    chk("mid.digit0", 32'(bank[0]), 32'h6);
    chk("mid.digit1", 32'(bank[1]), 32'h5);
    for (int i = 2; i < 6; i++) chk($sformatf("mid.digit%0d", i), 32'(bank[i]), 32'h9);
    next_cycle();

    // Lone requester B with pointer at A.
    do_reset();
    a_valid = 1'b0; b_valid = 1'b1; b_data = 24'hABCDEF;
    sample();
    chk("lone.b_ready", 32'(if0.b_ready), 1);
    chk("lone.a_ready", 32'(if0.a_ready), 0);
    next_cycle();
    b_valid = 1'b0;
    sample();
    chk("lone.last_grant", 32'(if0.last_grant), 1);
    repeat (6) next_cycle();
    a_valid = 1'b1; b_valid = 1'b1;
    sample();
    chk("lone.ptr_a_ready", 32'(if0.a_ready), 1);
    next_cycle();

    // Randomized traffic against the reference model, both instances.
    do_reset();
    run_random(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
